// File: rtl/disc_batch_controller.sv
// disc_batch_controller: serial weight loader and one-sample-at-a-time batch
// sequencer around a 9-3-1 discriminator. Optional: DISC_CTRL_ACCUM_EN.
module disc_batch_controller #(
  parameter int N_W1    = 30,
  parameter int N_W2    = 4,
  parameter int BATCH_W = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wvalid,
  input  logic [15:0]          cfg_wdata,
  output logic                 cfg_wready,
  input  logic                 start,
  input  logic [BATCH_W-1:0]   batch_len,
  input  logic                 s_valid,
  input  logic [143:0]         s_pix,
  output logic                 s_ready,
  output logic                 d_valid_in,
  output logic [143:0]         d_pix,
  output logic [16*N_W1-1:0]   flat_weights_D1,
  output logic [16*N_W2-1:0]   flat_weights_D2,
  input  logic                 d_valid_out,
  input  logic [15:0]          d_score,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [15:0]          m_score,
  output logic                 m_last,
  output logic                 busy,
  output logic                 weights_loaded,
  output logic                 timeout_err
`ifdef DISC_CTRL_ACCUM_EN
  ,
  output logic signed [BATCH_W+15:0] o_sum,
  output logic                 o_sum_valid
`endif
);

  localparam int NW = N_W1 + N_W2;
  localparam int PW = $clog2(NW);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_OUT
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [16*N_W1-1:0]   w1_q, w1_d;
  logic [16*N_W2-1:0]   w2_q, w2_d;
  logic                 wl_q, wl_d;
  logic [BATCH_W-1:0]   len_q, len_d;
  logic [BATCH_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 terr_q, terr_d;
  logic [143:0]         pix_q, pix_d;
  logic [15:0]          sc_q, sc_d;
  logic                 mv_q, mv_d;
  logic                 ml_q, ml_d;
`ifdef DISC_CTRL_ACCUM_EN
  logic signed [BATCH_W+15:0] sum_q, sum_d;
  logic                 sv_q, sv_d;
`endif

  // state and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      wl_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      terr_q  <= 1'b0;
      pix_q   <= '0;
      sc_q    <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
`ifdef DISC_CTRL_ACCUM_EN
      sum_q   <= '0;
      sv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      wl_q    <= wl_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      terr_q  <= terr_d;
      pix_q   <= pix_d;
      sc_q    <= sc_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
`ifdef DISC_CTRL_ACCUM_EN
      sum_q   <= sum_d;
      sv_q    <= sv_d;
`endif
    end
  end

  // next state: weight loading in IDLE, then fetch/issue/wait/out per sample
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    wl_d    = wl_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    terr_d  = terr_q;
    pix_d   = pix_q;
    sc_d    = sc_q;
    mv_d    = mv_q;
    ml_d    = ml_q;
`ifdef DISC_CTRL_ACCUM_EN
    sum_d   = sum_q;
    sv_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cfg_wvalid) begin
          for (int k = 0; k < N_W1; k++)
            if (wptr_q == PW'(k)) w1_d[16*k +: 16] = cfg_wdata;
          for (int k = 0; k < N_W2; k++)
            if (wptr_q == PW'(N_W1 + k)) w2_d[16*k +: 16] = cfg_wdata;
          if (wptr_q == '0) wl_d = 1'b0;
          if (wptr_q == PW'(NW - 1)) begin
            wl_d   = 1'b1;
            wptr_d = '0;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end else if (start && wl_q && wptr_q == '0 && batch_len != '0) begin
          len_d   = batch_len;
          cnt_d   = '0;
          terr_d  = 1'b0;
          state_d = S_FETCH;
`ifdef DISC_CTRL_ACCUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_FETCH: begin
        if (s_valid) begin
          pix_d   = s_pix;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (d_valid_out) begin
          sc_d    = d_score;
          mv_d    = 1'b1;
          ml_d    = (cnt_q == len_q - 1'b1);
          state_d = S_OUT;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          mv_d    = 1'b0;
          ml_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = ml_q ? S_IDLE : S_FETCH;
`ifdef DISC_CTRL_ACCUM_EN
          sum_d   = sum_q + {{BATCH_W{sc_q[15]}}, sc_q};
          sv_d    = ml_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_wready      = (state_q == S_IDLE);
  assign s_ready         = (state_q == S_FETCH);
  assign d_valid_in      = (state_q == S_ISSUE);
  assign busy            = (state_q != S_IDLE);
  assign d_pix           = pix_q;
  assign flat_weights_D1 = w1_q;
  assign flat_weights_D2 = w2_q;
  assign m_valid         = mv_q;
  assign m_score         = sc_q;
  assign m_last          = ml_q;
  assign weights_loaded  = wl_q;
  assign timeout_err     = terr_q;
`ifdef DISC_CTRL_ACCUM_EN
  assign o_sum           = sum_q;
  assign o_sum_valid     = sv_q;
`endif

endmodule

// File: tb/tb_disc_batch_controller.sv
// tb_disc_batch_controller: randomized batches through a stub discriminator,
// checked against a slot/queue model of the controller's contract.
module tb_disc_batch_controller;

  localparam int BW = 8;
  localparam int NW = 34;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wvalid;
  logic [15:0]   cfg_wdata;
  logic          cfg_wready;
  logic          start;
  logic [BW-1:0] batch_len;
  logic          s_valid;
  logic [143:0]  s_pix;
  logic          s_ready;
  logic          d_valid_in;
  logic [143:0]  d_pix;
  logic [479:0]  flat_weights_D1;
  logic [63:0]   flat_weights_D2;
  logic          d_valid_out = 1'b0;
  logic [15:0]   d_score = '0;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   m_score;
  logic          m_last;
  logic          busy;
  logic          weights_loaded;
  logic          timeout_err;
`ifdef DISC_CTRL_ACCUM_EN
  logic signed [BW+15:0] o_sum;
  logic          o_sum_valid;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] wm [NW];
  int          wp_m;
  bit          wl_m;

  logic [15:0] cur_score = '0;
  int          cur_lat = 1;
  bit          stub_on = 1'b1;
  int          stub_cnt = 0;
  logic [15:0] fixed_q [$];

  disc_batch_controller dut (
    .clk(clk), .rst(rst),
    .cfg_wvalid(cfg_wvalid), .cfg_wdata(cfg_wdata),
    .cfg_wready(cfg_wready),
    .start(start), .batch_len(batch_len),
    .s_valid(s_valid), .s_pix(s_pix), .s_ready(s_ready),
    .d_valid_in(d_valid_in), .d_pix(d_pix),
    .flat_weights_D1(flat_weights_D1),
    .flat_weights_D2(flat_weights_D2),
    .d_valid_out(d_valid_out), .d_score(d_score),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_score(m_score), .m_last(m_last),
    .busy(busy), .weights_loaded(weights_loaded),
    .timeout_err(timeout_err)
`ifdef DISC_CTRL_ACCUM_EN
    , .o_sum(o_sum), .o_sum_valid(o_sum_valid)
`endif
  );

  always #5 clk = ~clk;

  // stub discriminator: answers cur_lat+1 cycles after valid_in
  always @(posedge clk) begin
    d_valid_out <= 1'b0;
    if (rst) begin
      stub_cnt <= 0;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        d_valid_out <= 1'b1;
        d_score     <= cur_score;
      end
    end else if (d_valid_in && stub_on) begin
      stub_cnt <= cur_lat;
    end
  end

  task automatic chk(string tag, logic [479:0] got, logic [479:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int k = 0; k < NW; k++) wm[k] = '0;
    wp_m = 0;
    wl_m = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wl"}, weights_loaded, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_mv"}, m_valid, 0);
    chk({tag, "_ml"}, m_last, 0);
    chk({tag, "_msc"}, m_score, 0);
    chk({tag, "_dpix"}, d_pix, 0);
    chk({tag, "_dvin"}, d_valid_in, 0);
    chk({tag, "_srdy"}, s_ready, 0);
    chk({tag, "_d1"}, flat_weights_D1, 0);
    chk({tag, "_d2"}, flat_weights_D2, 0);
`ifdef DISC_CTRL_ACCUM_EN
    chk({tag, "_sum"}, $unsigned(o_sum), 0);
    chk({tag, "_sumv"}, o_sum_valid, 0);
`endif
  endtask

  task automatic chk_weights(string tag);
    logic [479:0] e1;
    logic [63:0]  e2;
    for (int k = 0; k < 30; k++) e1[16*k +: 16] = wm[k];
    for (int k = 0; k < 4; k++) e2[16*k +: 16] = wm[30 + k];
    chk({tag, "_d1"}, flat_weights_D1, e1);
    chk({tag, "_d2"}, flat_weights_D2, e2);
    chk({tag, "_wl"}, weights_loaded, wl_m);
  endtask

  task automatic load_words(int n, bit seq);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        cfg_wvalid = 1'b0;
        step();
      end
      chk("cfg_wready", cfg_wready, 1);
      cfg_wvalid = 1'b1;
      cfg_wdata  = seq ? 16'(wp_m + 1) : 16'($urandom);
      wm[wp_m] = cfg_wdata;
      if (wp_m == 0) wl_m = 1'b0;
      if (wp_m == NW - 1) begin
        wl_m = 1'b1;
        wp_m = 0;
      end else begin
        wp_m++;
      end
      step();
    end
    cfg_wvalid = 1'b0;
  endtask

  task automatic start_ignored(string tag, int len);
    start     = 1'b1;
    batch_len = BW'(len);
    step();
    start = 1'b0;
    chk(tag, busy, 0);
  endtask

  // hang=1: the stub stays silent and the first sample must time out
  task automatic run_batch(int len, bit hang);
    logic [143:0] pix;
    logic [15:0]  sc;
    longint       sum;
    int           w;
    int           k;
    start     = 1'b1;
    batch_len = BW'(len);
    step();
    start = 1'b0;
    sum   = 0;
    chk("start_busy", busy, 1);
    chk("terr_clear", timeout_err, 0);
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < 9; j++) pix[16*j +: 16] = 16'($urandom);
      chk("fetch_srdy", s_ready, 1);
      chk("fetch_dvin", d_valid_in, 0);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        step();
        chk("fetch_hold", s_ready, 1);
      end
      sc        = fixed_q.size() > 0 ? fixed_q.pop_front() : 16'($urandom);
      cur_score = sc;
      cur_lat   = $urandom_range(1, 6);
      s_valid   = 1'b1;
      s_pix     = pix;
      step();
      s_valid = 1'b0;
      chk("issue_dvin", d_valid_in, 1);
      chk("issue_dpix", d_pix, pix);
      chk("issue_cfgrdy", cfg_wready, 0);
      w = 0;
      step();
      chk("wait_dvin", d_valid_in, 0);
      while (busy && !m_valid && w < 100) begin
        w++;
        step();
      end
      if (hang) begin
        chk("to_wait_cycles", w, TO);
        chk("to_terr", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_mvalid", m_valid, 0);
        return;
      end
      chk("wait_cycles", w, cur_lat + 1);
      chk("out_mvalid", m_valid, 1);
      chk("out_score", m_score, sc);
      chk("out_last", m_last, i == len - 1);
      chk("out_dpix", d_pix, pix);
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) begin
        step();
        chk("stall_mv", m_valid, 1);
        chk("stall_sc", m_score, sc);
        chk("stall_srdy", s_ready, 0);
        chk("stall_dvin", d_valid_in, 0);
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      sum += longint'($signed(sc));
      chk("hs_mv", m_valid, 0);
      chk("hs_ml", m_last, 0);
`ifdef DISC_CTRL_ACCUM_EN
      chk("sum_pulse", o_sum_valid, i == len - 1);
      if (i == len - 1)
        chk("sum_val", $unsigned(o_sum), (BW+16)'(sum));
`endif
      if (i == len - 1) chk("end_busy", busy, 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_wvalid = 1'b0;
    cfg_wdata  = '0;
    start      = 1'b0;
    batch_len  = '0;
    s_valid    = 1'b0;
    s_pix      = '0;
    m_ready    = 1'b0;
    model_clear();
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_cfgrdy", cfg_wready, 1);

    start_ignored("start_no_weights", 3);
    load_words(10, 1'b1);
    chk_weights("partial");
    start_ignored("start_partial", 3);
    load_words(24, 1'b1);
    chk_weights("full");
    chk("d1_lo", flat_weights_D1[15:0], 16'h0001);
    chk("d1_hi", flat_weights_D1[479:464], 16'h001E);
    chk("d2_hi", flat_weights_D2[63:48], 16'h0022);
    start_ignored("start_len0", 0);

    run_batch(3, 1'b0);
    repeat (6) run_batch($urandom_range(1, 6), 1'b0);
    chk_weights("after_batches");

    stub_on = 1'b0;
    run_batch(2, 1'b1);
    stub_on = 1'b1;
    run_batch(2, 1'b0);

    cfg_wvalid = 1'b1;
    cfg_wdata  = 16'($urandom);
    start      = 1'b1;
    batch_len  = 8'd2;
    wm[0] = cfg_wdata;
    wl_m  = 1'b0;
    wp_m  = 1;
    step();
    cfg_wvalid = 1'b0;
    start      = 1'b0;
    chk("cfg_beats_start", busy, 0);
    chk_weights("slot0_rewrite");
    load_words(33, 1'b0);
    chk_weights("reload");

    fixed_q = '{16'h0100, 16'hFF00, 16'h0080};
    run_batch(3, 1'b0);
    run_batch(255, 1'b0);

    stub_on = 1'b0;
    start     = 1'b1;
    batch_len = 8'd2;
    step();
    start   = 1'b0;
    s_valid = 1'b1;
    s_pix   = {9{16'h1234}};
    step();
    s_valid = 1'b0;
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    chk_zero("mid_rst");
    rst = 1'b0;
    model_clear();
    step();
    chk("post_rst_busy", busy, 0);
    chk_weights("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
